ahbmtx_in_stage: RTL and testbench



---
 rtl/ahbmtx_pkg.sv | 50 +++++
 rtl/ahbmtx_in_stage.sv | 118 +++++++++++
 tb/tb_ahbmtx_in_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbmtx_pkg.sv
// ------------------------------------------------------------------
// ahbmtx_pkg : AHB encodings and address-phase types for the matrix
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ahbmtx_pkg;

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;

    localparam logic C_HRESP_OKAY  = 1'b0;
    localparam logic C_HRESP_ERROR = 1'b1;

    localparam logic [2:0] C_HBURST_SINGLE = 3'd0;
    localparam logic [2:0] C_HBURST_INCR   = 3'd1;
    localparam logic [2:0] C_HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] C_HBURST_INCR4  = 3'd3;
    localparam logic [2:0] C_HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] C_HBURST_INCR8  = 3'd5;
    localparam logic [2:0] C_HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] C_HBURST_INCR16 = 3'd7;

    localparam logic [2:0] C_HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] C_HSIZE_HALF  = 3'd1;
    localparam logic [2:0] C_HSIZE_WORD  = 3'd2;
    localparam logic [2:0] C_HSIZE_DWORD = 3'd3;
    localparam logic [2:0] C_HSIZE_4WORD = 3'd4;
    localparam logic [2:0] C_HSIZE_8WORD = 3'd5;

    // Address-phase control fields, everything except the address itself
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } ahb_ctrl_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never request
    function automatic logic trans_requests(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahbmtx_in_stage.sv
// ------------------------------------------------------------------
// ahbmtx_in_stage : slave-side input stage (hold, request, data phase)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ahbmtx_in_stage
    import ahbmtx_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        trans_i,
    output logic              write_i,
    output logic [2:0]        size_i,
    output logic [2:0]        burst_i,
    output logic [3:0]        prot_i,
    output logic              lock_i,
    output logic              trans_pend,
    input  logic              active_addr,
    input  logic              data_ready,
    input  logic              data_resp
);

    logic              r_pend;
    logic              r_data_active;
    logic [ADDR_W-1:0] r_hold_addr;
    ahb_ctrl_t         r_hold_ctrl;

    ahb_ctrl_t         w_live_ctrl;
    ahb_ctrl_t         w_fwd_ctrl;
    logic              w_valid;
    logic              w_capture;
    logic              w_grant;

    always_comb begin
        w_live_ctrl       = '0;
        w_live_ctrl.trans = HTRANSS;
        w_live_ctrl.write = HWRITES;
        w_live_ctrl.size  = HSIZES;
        w_live_ctrl.burst = HBURSTS;
        w_live_ctrl.prot  = HPROTS;
        w_live_ctrl.lock  = HMASTLOCKS;
    end

    assign w_valid   = HSELS & HREADYS & trans_requests(HTRANSS);
    // Sampling is suppressed while a held transfer waits for its grant
    assign w_capture = ~r_pend & w_valid & ~active_addr;
    assign w_grant   = active_addr & (r_pend | w_valid);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_hold_addr <= '0;
            r_hold_ctrl <= '0;
        end else if (w_capture) begin
            r_hold_addr <= HADDRS;
            r_hold_ctrl <= w_live_ctrl;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_pend <= 1'b0;
        end else if (r_pend & active_addr) begin
            r_pend <= 1'b0;
        end else if (w_capture) begin
            r_pend <= 1'b1;
        end
    end

    // A grant in the completing cycle keeps the data phase open back-to-back
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_data_active <= 1'b0;
        end else if (w_grant) begin
            r_data_active <= 1'b1;
        end else if (data_ready) begin
            r_data_active <= 1'b0;
        end
    end

    always_comb begin
        addr_i     = HADDRS;
        w_fwd_ctrl = w_live_ctrl;
        trans_pend = w_valid;
        if (r_pend) begin
            addr_i     = r_hold_addr;
            w_fwd_ctrl = r_hold_ctrl;
            trans_pend = 1'b1;
        end
    end

    assign trans_i = w_fwd_ctrl.trans;
    assign write_i = w_fwd_ctrl.write;
    assign size_i  = w_fwd_ctrl.size;
    assign burst_i = w_fwd_ctrl.burst;
    assign prot_i  = w_fwd_ctrl.prot;
    assign lock_i  = w_fwd_ctrl.lock;

    assign HREADYOUTS = r_data_active ? data_ready : ~r_pend;
    assign HRESPS     = r_data_active ? data_resp  : C_HRESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_ahbmtx_in_stage.sv
// Directed bench for ahbmtx_in_stage; per-cycle expectations are queued
// as stimulus is applied and checked on the following falling edge.
`default_nettype none

module tb_ahbmtx_in_stage;

    logic        clk;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic [31:0] addr_i;
    logic [1:0]  trans_i;
    logic        write_i;
    logic [2:0]  size_i;
    logic [2:0]  burst_i;
    logic [3:0]  prot_i;
    logic        lock_i;
    logic        trans_pend;
    logic        active_addr;
    logic        data_ready;
    logic        data_resp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        rdy;
        logic        resp;
        logic        tp;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_ctrl;
        logic [13:0] ctrl;
    } exp_t;

    exp_t sb[$];

    ahbmtx_in_stage #(.ADDR_W(32)) dut (
        .HCLK       (clk),
        .HRESET     (HRESET),
        .HSELS      (HSELS),
        .HADDRS     (HADDRS),
        .HTRANSS    (HTRANSS),
        .HWRITES    (HWRITES),
        .HSIZES     (HSIZES),
        .HBURSTS    (HBURSTS),
        .HPROTS     (HPROTS),
        .HMASTLOCKS (HMASTLOCKS),
        .HREADYS    (HREADYS),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .addr_i     (addr_i),
        .trans_i    (trans_i),
        .write_i    (write_i),
        .size_i     (size_i),
        .burst_i    (burst_i),
        .prot_i     (prot_i),
        .lock_i     (lock_i),
        .trans_pend (trans_pend),
        .active_addr(active_addr),
        .data_ready (data_ready),
        .data_resp  (data_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic rdy, input logic resp, input logic tp,
                            input logic chk_addr = 1'b0, input logic [31:0] addr = 32'h0,
                            input logic chk_ctrl = 1'b0, input logic [13:0] ctrl = 14'h0);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.resp = resp; e.tp = tp;
        e.chk_addr = chk_addr; e.addr = addr; e.chk_ctrl = chk_ctrl; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".hreadyout"}, {31'd0, HREADYOUTS}, {31'd0, e.rdy});
            cmp({e.tag, ".hresp"},     {31'd0, HRESPS},     {31'd0, e.resp});
            cmp({e.tag, ".trans_pend"}, {31'd0, trans_pend}, {31'd0, e.tp});
            if (e.chk_addr) cmp({e.tag, ".addr_i"}, addr_i, e.addr);
            if (e.chk_ctrl)
                cmp({e.tag, ".ctrl"},
                    {18'd0, trans_i, write_i, size_i, burst_i, prot_i, lock_i},
                    {18'd0, e.ctrl});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic act, input logic drdy, input logic dresp = 1'b0,
                         input logic hrdy = 1'b1);
        HSELS = sel; HTRANSS = trans; HADDRS = addr; active_addr = act;
        data_ready = drdy; data_resp = dresp; HREADYS = hrdy;
    endtask

    initial begin
        HRESET = 1'b1;
        HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0; HBURSTS = 0;
        HPROTS = 0; HMASTLOCKS = 0; HREADYS = 1; active_addr = 0; data_ready = 1; data_resp = 0;
        push_exp("reset", 1, 0, 0);
        cycle();
        HRESET = 1'b0;

        // Granted single write, slave inserts two wait states
        HWRITES = 1;
        drive(1, 2'b10, 32'h2000_0010, 1, 1);
        push_exp("grant.addr", 1, 0, 1, 1, 32'h2000_0010);
        cycle();
        HWRITES = 0;
        drive(0, 2'b00, 32'h0, 0, 0);
        push_exp("grant.wait1", 0, 0, 0);
        cycle();
        push_exp("grant.wait2", 0, 0, 0);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 1);
        push_exp("grant.done", 1, 0, 0);
        cycle();

        // Held transfer: denied three cycles, granted on the fourth
        HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'b0011; HMASTLOCKS = 1;
        drive(1, 2'b10, 32'h4000_0000, 0, 1);
        push_exp("hold.capture", 1, 0, 1, 1, 32'h4000_0000);
        cycle();
        HSIZES = 3'd0; HBURSTS = 3'd1; HPROTS = 4'b1100; HMASTLOCKS = 0;
        drive(1, 2'b11, 32'h5555_0000, 0, 1);
        push_exp("hold.wait1", 0, 0, 1, 1, 32'h4000_0000, 1, {2'b10, 1'b0, 3'd2, 3'd0, 4'b0011, 1'b1});
        cycle();
        drive(0, 2'b00, 32'h6666_0000, 0, 1);
        push_exp("hold.wait2", 0, 0, 1, 1, 32'h4000_0000);
        cycle();
        drive(1, 2'b11, 32'h7777_0000, 1, 1);
        push_exp("hold.grant", 0, 0, 1, 1, 32'h4000_0000, 1, {2'b10, 1'b0, 3'd2, 3'd0, 4'b0011, 1'b1});
        cycle();
        drive(0, 2'b00, 32'h0000_1234, 0, 0);
        push_exp("hold.dphase", 0, 0, 0, 1, 32'h0000_1234);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 1);
        push_exp("hold.done", 1, 0, 0);
        cycle();

        // INCR4 burst, granted every beat, one stalled beat
        HBURSTS = 3'd3; HSIZES = 3'd2; HPROTS = 0;
        drive(1, 2'b10, 32'h0000_1000, 1, 1);
        push_exp("burst.b0", 1, 0, 1, 1, 32'h0000_1000);
        cycle();
        drive(1, 2'b11, 32'h0000_1004, 1, 0, 0, 0);
        push_exp("burst.stall", 0, 0, 0);
        cycle();
        drive(1, 2'b11, 32'h0000_1004, 1, 1);
        push_exp("burst.b1", 1, 0, 1, 1, 32'h0000_1004);
        cycle();
        drive(1, 2'b11, 32'h0000_1008, 1, 1);
        push_exp("burst.b2", 1, 0, 1);
        cycle();
        drive(1, 2'b11, 32'h0000_100C, 1, 1);
        push_exp("burst.b3", 1, 0, 1);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 1);
        push_exp("burst.last", 1, 0, 0);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 0);
        push_exp("burst.closed", 1, 0, 0);
        cycle();

        // ERROR passthrough followed by a held transfer
        HBURSTS = 3'd0;
        drive(1, 2'b10, 32'h0000_3000, 1, 1);
        push_exp("err.addr", 1, 0, 1);
        cycle();
        drive(1, 2'b10, 32'h0000_3100, 0, 0, 1, 0);
        push_exp("err.first", 0, 1, 0);
        cycle();
        drive(1, 2'b10, 32'h0000_3100, 0, 1, 1, 1);
        push_exp("err.second", 1, 1, 1, 1, 32'h0000_3100);
        cycle();
        drive(1, 2'b00, 32'h0000_3F00, 0, 1, 0, 1);
        push_exp("err.held", 0, 0, 1, 1, 32'h0000_3100);
        cycle();
        drive(1, 2'b00, 32'h0000_3F00, 1, 1, 0, 1);
        push_exp("err.fwd", 0, 0, 1, 1, 32'h0000_3100);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 1);
        push_exp("err.done", 1, 0, 0);
        cycle();

        // IDLE, BUSY and unselected never request or capture
        drive(1, 2'b00, 32'h0000_5000, 0, 0, 1);
        push_exp("idle", 1, 0, 0);
        cycle();
        drive(1, 2'b01, 32'h0000_5000, 0, 0, 1);
        push_exp("busy", 1, 0, 0);
        cycle();
        drive(0, 2'b10, 32'h0000_5000, 0, 0, 1);
        push_exp("unsel", 1, 0, 0);
        cycle();
        drive(0, 2'b00, 32'h0000_5004, 0, 0, 1);
        push_exp("nocapture", 1, 0, 0, 1, 32'h0000_5004);
        cycle();

        // Reset in the middle of a hold with the prior data phase open
        drive(1, 2'b10, 32'h0000_8000, 1, 1);
        push_exp("rst.addr", 1, 0, 1);
        cycle();
        drive(1, 2'b10, 32'h0000_8100, 0, 0);
        push_exp("rst.capture", 0, 0, 1, 1, 32'h0000_8100);
        cycle();
        drive(0, 2'b00, 32'h0, 0, 0, 1);
        push_exp("rst.pending", 0, 1, 1, 1, 32'h0000_8100);
        cycle();
        HRESET = 1'b1;
        #1;
        push_exp("rst.async", 1, 0, 0);
        check_now();
        @(posedge clk);
        #1;
        HRESET = 1'b0;
        drive(0, 2'b00, 32'h0, 0, 0, 1);
        push_exp("rst.after1", 1, 0, 0, 1, 32'h0);
        cycle();
        drive(0, 2'b00, 32'h0, 1, 1);
        push_exp("rst.after2", 1, 0, 0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
